// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_SHL1 = 3'b110,
        OP_CMP  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: start loads operands, done pulses on the W-th iteration.
// product is the combinational value of that final iteration, so the caller registers it alongside done.
module alu_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CW = $clog2(W);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           running;

    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = running && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            acc     <= '0;
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
            cnt     <= CW'(W - 1);
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides; result registered at the accept edge (MUL: W cycles later).
// in_ready drops while multiplying or while a held result is not being taken; one transaction in flight.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           flag_z,
    output logic           flag_c,
    output logic           busy
);
    localparam int RW = 2 * W;

    state_e         state, state_nxt;
    op_e            op_in;
    logic           accept;
    logic           mul_start;
    logic           mul_done;
    logic [RW-1:0]  mul_product;
    logic [RW-1:0]  alu_res;
    logic           alu_c;

    assign op_in     = op_e'(op);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state == ST_MUL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_MUL: begin
                if (mul_done) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A HOLD->new-request handoff overrides the drop to IDLE in the same cycle.
        accept = in_valid && in_ready;
        if (accept) begin
            mul_start = (op_in == OP_MUL);
            state_nxt = (op_in == OP_MUL) ? ST_MUL : ST_HOLD;
        end
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_in)
            OP_ADD: begin
                alu_res = {{W{1'b0}}, a} + {{W{1'b0}}, b};
                alu_c   = alu_res[W];
            end
            OP_SUB: begin
                alu_res = {{W{1'b0}}, a - b};
                alu_c   = (a < b);
            end
            OP_AND:  alu_res = {{W{1'b0}}, a & b};
            OP_OR:   alu_res = {{W{1'b0}}, a | b};
            OP_XOR:  alu_res = {{W{1'b0}}, a ^ b};
            OP_SHL1: begin
                alu_res = {{(W-1){1'b0}}, a, 1'b0};
                alu_c   = a[W-1];
            end
            OP_CMP: begin
                alu_res = {{(RW-1){1'b0}}, (a >= b)};
                alu_c   = (a == b);
            end
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else if (accept && (op_in != OP_MUL)) begin
            result <= alu_res;
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
        end else if ((state == ST_MUL) && mul_done) begin
            result <= mul_product;
            flag_z <= (mul_product == '0);
            flag_c <= 1'b0;
        end
    end

    alu_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (W=8): expected responses are queued at issue and popped by a monitor.
module tb_alu_seq;
    localparam int W = 8;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] XOR_ = 3'b100, MUL = 3'b101, SHL1 = 3'b110, CMP = 3'b111;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [2:0]     op = 3'b000;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready, out_valid, flag_z, flag_c, busy;
    logic [2*W-1:0] result;

    int n_chk = 0;
    int n_fail = 0;
    int run_len = 0;
    int max_run = 0;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        c;
    } exp_t;

    typedef struct {
        logic [2:0]  o;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] res;
        logic        z;
        logic        c;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    vec_t tbl [9] = '{
        '{ADD,  8'd255, 8'd255, 16'd510, 1'b0, 1'b1},
        '{ADD,  8'd0,   8'd0,   16'd0,   1'b1, 1'b0},
        '{SUB,  8'd7,   8'd5,   16'd2,   1'b0, 1'b0},
        '{SUB,  8'd0,   8'd0,   16'd0,   1'b1, 1'b0},
        '{SHL1, 8'h40,  8'h00,  16'h080, 1'b0, 1'b0},
        '{CMP,  8'd3,   8'd9,   16'd0,   1'b1, 1'b0},
        '{CMP,  8'd9,   8'd3,   16'd1,   1'b0, 1'b0},
        '{MUL,  8'd0,   8'd77,  16'd0,   1'b1, 1'b0},
        '{MUL,  8'd15,  8'd17,  16'd255, 1'b0, 1'b0}
    };

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Present a request from just after a rising edge; returns after the accepting edge (+1).
    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int waits);
        bit ok;
        ok       = 1'b0;
        waits    = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: op=%0d never accepted, required acceptance within 64 cycles", o);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] res, input logic z, input logic c, output int waits);
        exp_t e;
        e.res = res;
        e.z   = z;
        e.c   = c;
        sb.push_back(e);
        send(o, x, y, waits);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: result=%0h appeared, required no output", result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("mon_result", 32'(result), 32'(mon_e.res));
                    chk("mon_flag_z", 32'(flag_z), 32'(mon_e.z));
                    chk("mon_flag_c", 32'(flag_c), 32'(mon_e.c));
                end
            end else begin
                run_len = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int vld_cnt;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_flag_z",    32'(flag_z),    32'd0);
        chk("rst_flag_c",    32'(flag_c),    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        issue(ADD, 8'd200, 8'd100, 16'd300, 1'b0, 1'b1, w);
        @(negedge clk);
        chk("add_valid_next_cycle", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        issue(SUB, 8'd5, 8'd7, 16'd254, 1'b0, 1'b1, w);
        issue(CMP, 8'd9, 8'd9, 16'd1,   1'b0, 1'b1, w);

        issue(MUL, 8'd255, 8'd255, 16'd65025, 1'b0, 1'b0, w);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy",      32'(busy),      32'd1);
            chk("mul_in_ready",  32'(in_ready),  32'd0);
            chk("mul_out_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("mul_done_busy",  32'(busy),      32'd0);
        chk("mul_done_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        issue(XOR_, 8'h5A, 8'h5A, 16'd0, 1'b1, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid",    32'(out_valid), 32'd1);
            chk("hold_result",   32'(result),    32'd0);
            chk("hold_flag_z",   32'(flag_z),    32'd1);
            chk("hold_in_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(ADD, 8'd3, 8'd4, 16'd7, 1'b0, 1'b0, w);
        chk("hold_same_cycle_accept_waits", 32'(w), 32'd0);
        @(negedge clk);
        chk("handoff_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            issue(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].res, tbl[i].z, tbl[i].c, w);
        end
        @(posedge clk);
        #1;

        send(MUL, 8'd13, 8'd11, w);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result",    32'(result),    32'd0);
        rst_n = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) vld_cnt++;
        end
        chk("abort_no_stale_valid", 32'(vld_cnt), 32'd0);
        @(posedge clk);
        #1;

        max_run = 0;
        issue(AND_, 8'hF0, 8'h3C, 16'h030, 1'b0, 1'b0, w);
        issue(OR_,  8'hF0, 8'h0C, 16'h0FC, 1'b0, 1'b0, w);
        issue(SHL1, 8'h81, 8'h00, 16'h102, 1'b0, 1'b1, w);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_consecutive_valid", 32'(max_run), 32'd3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
